// File: rtl/det_sched_pkg.sv
// Shared types for the round-robin sequence-detector scheduler.
package det_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } sched_state_e;

  // Index width that stays legal (>=1 bit) for a single requester.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority pick: first set req bit at or above ptr, with wrap.
module rr_arbiter
  import det_sched_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any_req
);

  always_comb begin
    logic found;
    int   c;
    gnt     = '0;
    idx     = '0;
    any_req = |req;
    found   = 1'b0;
    c       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      c = int'(ptr) + i;
      if (c >= N_REQ) c = c - N_REQ;
      if (!found && req[c]) begin
        found  = 1'b1;
        idx    = c[IDX_W-1:0];
        gnt[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/det_rr_scheduler.sv
// Time-shares one serial sequence detector among N_REQ lanes, one frame per grant.
// Optional DET_SCHED_ABORT_EN: dropping req[owner] mid-stream ends the frame early with abort.
module det_rr_scheduler
  import det_sched_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int FRAME_LEN = 8,
  parameter  int CNT_W     = 10,
  localparam int IDX_W     = idx_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       bit_in,
  output logic [N_REQ-1:0]       grant,
  output logic [IDX_W-1:0]       owner,
  output logic                   busy,
  output logic                   det_clr,
  output logic                   det_x,
  input  logic                   det_y,
  output logic                   frame_done,
  output logic                   abort,
  output logic [N_REQ*CNT_W-1:0] user_cnt
);

  sched_state_e     state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [7:0]       bit_cnt_q, bit_cnt_d;
  logic             cnt_inc;

  logic [N_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;

`ifdef DET_SCHED_ABORT_EN
  logic aborted_q, aborted_d;
`endif

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req     (req),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .idx     (arb_idx),
    .any_req (arb_any)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    bit_cnt_d  = bit_cnt_q;
    det_clr    = 1'b0;
    det_x      = 1'b0;
    frame_done = 1'b0;
    abort      = 1'b0;
    cnt_inc    = 1'b0;
`ifdef DET_SCHED_ABORT_EN
    aborted_d  = aborted_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          owner_d = arb_idx;
          grant_d = arb_gnt;
          state_d = S_CLR;
`ifdef DET_SCHED_ABORT_EN
          aborted_d = 1'b0;
`endif
        end
      end
      S_CLR: begin
        det_clr   = 1'b1;
        bit_cnt_d = '0;
        state_d   = S_STREAM;
      end
      S_STREAM: begin
        det_x     = bit_in[owner_q];
        bit_cnt_d = bit_cnt_q + 8'd1;
        // det_y lags det_x by one cycle, so the first stream cycle carries nothing of ours
        cnt_inc   = det_y && (bit_cnt_q != 8'd0);
        if (bit_cnt_q == 8'(FRAME_LEN - 1)) state_d = S_DRAIN;
`ifdef DET_SCHED_ABORT_EN
        if (!req[owner_q]) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
          cnt_inc   = 1'b0;
        end
`endif
      end
      S_DRAIN: begin
        cnt_inc = det_y;
        state_d = S_DONE;
      end
      S_DONE: begin
        frame_done = 1'b1;
        grant_d    = '0;
        rr_ptr_d   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
        state_d    = S_IDLE;
`ifdef DET_SCHED_ABORT_EN
        abort      = aborted_q;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      bit_cnt_q <= '0;
`ifdef DET_SCHED_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      bit_cnt_q <= bit_cnt_d;
`ifdef DET_SCHED_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (cnt_inc && (owner_q == IDX_W'(i)) && (cnt_q != {CNT_W{1'b1}}))
        cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end

    assign user_cnt[i*CNT_W +: CNT_W] = cnt_q;
  end

  assign grant = grant_q;
  assign owner = owner_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_det_rr_scheduler.sv
// Directed bench for det_rr_scheduler with a "1 then 1" detector model on det_x/det_y.
module tb_det_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  bit_in = '0;
  logic [3:0]  grant, grant_s;
  logic [1:0]  owner, owner_s;
  logic        busy, busy_s, det_clr, det_clr_s, det_x, det_x_s;
  logic        frame_done, frame_done_s, abort, abort_s;
  logic        det_y;
  logic [39:0] user_cnt;
  logic [7:0]  user_cnt_s;

  int n_chk = 0;
  int n_fail = 0;
  int g0_cyc = 0, g2_cyc = 0, clr_n = 0, done_n = 0, abort_n = 0;

  always #5 clk = ~clk;

  det_rr_scheduler #(.N_REQ(4), .FRAME_LEN(8), .CNT_W(10)) dut (
    .clk(clk), .rst(rst), .req(req), .bit_in(bit_in), .grant(grant), .owner(owner),
    .busy(busy), .det_clr(det_clr), .det_x(det_x), .det_y(det_y),
    .frame_done(frame_done), .abort(abort), .user_cnt(user_cnt)
  );

  // Narrow-counter copy sees identical stimulus, so the same det_y applies.
  det_rr_scheduler #(.N_REQ(4), .FRAME_LEN(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req(req), .bit_in(bit_in), .grant(grant_s), .owner(owner_s),
    .busy(busy_s), .det_clr(det_clr_s), .det_x(det_x_s), .det_y(det_y),
    .frame_done(frame_done_s), .abort(abort_s), .user_cnt(user_cnt_s)
  );

  // Detector model: registered flag, high when the last two bits were both 1.
  logic prev_b;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_b <= 1'b0; det_y <= 1'b0;
    end else if (det_clr) begin
      prev_b <= 1'b0; det_y <= 1'b0;
    end else begin
      det_y  <= prev_b & det_x;
      prev_b <= det_x;
    end
  end

  always @(negedge clk) begin
    if (grant[0]) g0_cyc++;
    if (grant[2]) g2_cyc++;
    if (det_clr) clr_n++;
    if (frame_done) done_n++;
    if (abort) abort_n++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst = 1'b1; req = '0; bit_in = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Waits for det_clr, streams pat (bit k in STREAM cycle k), optionally rewrites req
  // at STREAM cycle mid_k; returns at the negedge where frame_done is seen.
  task automatic drive_frame(input logic [7:0] pat, input int mid_k, input logic [3:0] mid_req,
                             output int own, output int waited, output int len, output bit to);
    to = 1'b0; waited = 0; len = 0; own = 0;
    while (det_clr !== 1'b1 && waited < 40) begin
      @(negedge clk); waited++;
    end
    if (det_clr !== 1'b1) begin
      to = 1'b1;
      return;
    end
    own = int'(owner);
    while (len < 20) begin
      @(negedge clk);
      if (frame_done === 1'b1) break;
      bit_in = '0;
      if (len < 8) begin
        bit_in[own] = pat[len];
        if (len == mid_k) req = mid_req;
      end
      len++;
    end
    bit_in = '0;
    if (frame_done !== 1'b1) to = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_chk++; if (grant !== 4'b0) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
    n_chk++; if (owner !== 2'd0) begin n_fail++; $display("FAIL reset_owner: got %0d want 0", owner); end
    n_chk++; if ({busy, det_clr, det_x, frame_done, abort} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctl: got %b want 00000", {busy, det_clr, det_x, frame_done, abort}); end
    n_chk++; if (user_cnt !== 40'd0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", user_cnt); end
    apply_reset();
  endtask

  task automatic test_single_lane();
    int own, w, len, g0, c0, d0;
    bit to;
    apply_reset();
    g0 = g0_cyc; c0 = clr_n; d0 = done_n;
    req = 4'b0001;
    drive_frame(8'b0011_0110, -1, 4'b0000, own, w, len, to);
    req = 4'b0000;
    @(negedge clk); #1;
    n_chk++; if (to !== 1'b0) begin n_fail++; $display("FAIL single_timeout: got %0d want 0", to); end
    n_chk++; if (own !== 0) begin n_fail++; $display("FAIL single_owner: got %0d want 0", own); end
    n_chk++; if (len !== 9) begin n_fail++; $display("FAIL single_len: got %0d want 9", len); end
    n_chk++; if (g0_cyc - g0 !== 11) begin n_fail++; $display("FAIL single_grant_cycles: got %0d want 11", g0_cyc - g0); end
    n_chk++; if (clr_n - c0 !== 1) begin n_fail++; $display("FAIL single_clr: got %0d want 1", clr_n - c0); end
    n_chk++; if (done_n - d0 !== 1) begin n_fail++; $display("FAIL single_done: got %0d want 1", done_n - d0); end
    n_chk++; if (user_cnt[9:0] !== 10'd2) begin n_fail++; $display("FAIL single_cnt: got %0d want 2", user_cnt[9:0]); end
    n_chk++; if (busy !== 1'b0 || grant !== 4'b0) begin n_fail++; $display("FAIL single_idle: got busy=%b grant=%b want 0 0000", busy, grant); end
  endtask

  task automatic test_round_robin();
    int exp_o [5];
    int own, w, len, g2;
    bit to;
    exp_o = '{0, 1, 3, 0, 1};
    apply_reset();
    g2 = g2_cyc;
    req = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      drive_frame(8'h00, -1, 4'b0000, own, w, len, to);
      n_chk++; if (to !== 1'b0 || own !== exp_o[i]) begin
        n_fail++; $display("FAIL rr_owner[%0d]: got %0d (to=%0d) want %0d", i, own, to, exp_o[i]); end
      if (i > 0) begin
        n_chk++; if (w !== 2) begin n_fail++; $display("FAIL rr_gap[%0d]: got %0d want 2", i, w); end
      end
    end
    req = 4'b0000;
    @(negedge clk); #1;
    n_chk++; if (g2_cyc - g2 !== 0) begin n_fail++; $display("FAIL rr_lane2: got %0d want 0", g2_cyc - g2); end
  endtask

  task automatic test_late_request();
    int own, w, len;
    bit to;
    apply_reset();
    req = 4'b0001;
    drive_frame(8'h00, 3, 4'b0101, own, w, len, to);
    n_chk++; if (to !== 1'b0 || own !== 0) begin n_fail++; $display("FAIL late_first: got %0d want 0", own); end
    drive_frame(8'h00, -1, 4'b0000, own, w, len, to);
    n_chk++; if (to !== 1'b0 || own !== 2) begin n_fail++; $display("FAIL late_second: got %0d want 2", own); end
    drive_frame(8'h00, -1, 4'b0000, own, w, len, to);
    n_chk++; if (to !== 1'b0 || own !== 0) begin n_fail++; $display("FAIL late_third: got %0d want 0", own); end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    int own, w, len;
    bit to;
    apply_reset();
    req = 4'b0010;
    drive_frame(8'b0000_1111, -1, 4'b0000, own, w, len, to);
    #1;
    n_chk++; if (to !== 1'b0 || own !== 1) begin n_fail++; $display("FAIL sat_owner: got %0d want 1", own); end
    n_chk++; if (user_cnt_s[3:2] !== 2'd3) begin n_fail++; $display("FAIL sat_first: got %0d want 3", user_cnt_s[3:2]); end
    drive_frame(8'b0000_0111, -1, 4'b0000, own, w, len, to);
    req = 4'b0000;
    @(negedge clk); #1;
    n_chk++; if (user_cnt_s[3:2] !== 2'd3) begin n_fail++; $display("FAIL sat_hold: got %0d want 3", user_cnt_s[3:2]); end
    n_chk++; if (user_cnt[19:10] !== 10'd5) begin n_fail++; $display("FAIL sat_wide: got %0d want 5", user_cnt[19:10]); end
  endtask

  task automatic test_reset_mid_frame();
    int own, w, len;
    bit to;
    apply_reset();
    req = 4'b0001;
    drive_frame(8'h00, -1, 4'b0000, own, w, len, to);
    req = 4'b0011;
    w = 0;
    while (det_clr !== 1'b1 && w < 40) begin @(negedge clk); w++; end
    n_chk++; if (det_clr !== 1'b1 || owner !== 2'd1) begin
      n_fail++; $display("FAIL rstmid_owner: got %0d (clr=%b) want 1", owner, det_clr); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); bit_in = 4'b0010;
    end
    @(negedge clk);
    n_chk++; if (user_cnt[19:10] !== 10'd2) begin n_fail++; $display("FAIL rstmid_pre_cnt: got %0d want 2", user_cnt[19:10]); end
    rst = 1'b1;
    #1;
    n_chk++; if (grant !== 4'b0 || owner !== 2'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_outs: got grant=%b owner=%0d busy=%b want 0000 0 0", grant, owner, busy); end
    n_chk++; if (det_x !== 1'b0 || user_cnt !== 40'd0) begin
      n_fail++; $display("FAIL rstmid_cnt: got det_x=%b cnt=%h want 0 0", det_x, user_cnt); end
    bit_in = '0;
    @(negedge clk);
    rst = 1'b0;
    drive_frame(8'h00, -1, 4'b0000, own, w, len, to);
    n_chk++; if (to !== 1'b0 || own !== 0) begin n_fail++; $display("FAIL rstmid_regrant: got %0d want 0", own); end
    req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_abort();
    int own, w, len, a0;
    bit to;
    logic ab;
    apply_reset();
    a0 = abort_n;
    req = 4'b0001;
    drive_frame(8'hFF, 3, 4'b0000, own, w, len, to);
    ab = abort;
    @(negedge clk); #1;
    n_chk++; if (to !== 1'b0) begin n_fail++; $display("FAIL abort_timeout: got %0d want 0", to); end
`ifdef DET_SCHED_ABORT_EN
    n_chk++; if (len !== 4) begin n_fail++; $display("FAIL abort_len: got %0d want 4", len); end
    n_chk++; if (ab !== 1'b1) begin n_fail++; $display("FAIL abort_pulse: got %b want 1", ab); end
    n_chk++; if (abort_n - a0 !== 1) begin n_fail++; $display("FAIL abort_count: got %0d want 1", abort_n - a0); end
    n_chk++; if (user_cnt[9:0] !== 10'd1) begin n_fail++; $display("FAIL abort_cnt: got %0d want 1", user_cnt[9:0]); end
`else
    n_chk++; if (len !== 9) begin n_fail++; $display("FAIL noabort_len: got %0d want 9", len); end
    n_chk++; if (ab !== 1'b0 || abort_n - a0 !== 0) begin
      n_fail++; $display("FAIL noabort_pulse: got %b/%0d want 0/0", ab, abort_n - a0); end
    n_chk++; if (user_cnt[9:0] !== 10'd7) begin n_fail++; $display("FAIL noabort_cnt: got %0d want 7", user_cnt[9:0]); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_round_robin();
    test_late_request();
    test_saturation();
    test_reset_mid_frame();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
